// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: byte-lane data RAM, load extension, result select.
// Define MMIO_GPIO_EN to map a GPIO register at GPIO_ADDR instead of the RAM word it would alias.
module mem_wb_stage #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] GPIO_ADDR   = 32'h8000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        RegWriteM,
   input  logic [2:0]  ResultSrcM,
   input  logic        MemWriteM,
   input  logic [2:0]  StrobeM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  RdM,
   input  logic [31:0] ExtImmM,
   input  logic [31:0] PcTargetM,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] GpioIn,
   output logic        RegWriteW,
   output logic [4:0]  RdW,
   output logic [31:0] ResultW,
   output logic        MisalignW,
   output logic [31:0] GpioOut
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   ram [DEPTH_WORDS];
   logic [AW-1:0] wordIdx;
   logic [3:0]    laneEn, ramWe;
   logic [31:0]   laneData, readWord, memWord;
   logic          sizeMisalign, isLoad, misalignedLoad, isGpio;

   logic [2:0]    resultSrcW, strobeW;
   logic [1:0]    addrLoW;
   logic [31:0]   aluW, extImmW, pcTargetW, pcPlus4W, loadWordW;
   logic [31:0]   byteWord, loadValue;
   logic [15:0]   halfSel;

   assign wordIdx        = ALUResultM[AW+1:2];
   assign isLoad         = (ResultSrcM == 3'b001);
   assign misalignedLoad = sizeMisalign & isLoad;

   // Store data is replicated across lanes so the lane enables alone pick the target bytes
   always_comb begin
      laneEn       = 4'b0000;
      laneData     = WriteDataM;
      sizeMisalign = 1'b0;
      case (StrobeM)
         3'b000, 3'b100: begin
            laneEn   = 4'b0001 << ALUResultM[1:0];
            laneData = {4{WriteDataM[7:0]}};
         end
         3'b001, 3'b101: begin
            laneEn       = ALUResultM[1] ? 4'b1100 : 4'b0011;
            laneData     = {2{WriteDataM[15:0]}};
            sizeMisalign = ALUResultM[0];
         end
         3'b010: begin
            laneEn       = 4'b1111;
            sizeMisalign = |ALUResultM[1:0];
         end
         default: ;
      endcase
   end

`ifdef MMIO_GPIO_EN
   assign isGpio  = (ALUResultM == GPIO_ADDR);
   assign memWord = isGpio ? GpioIn : readWord;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         GpioOut <= '0;
      end else if (MemWriteM && !sizeMisalign && isGpio) begin
         for (int i = 0; i < 4; i++)
            if (laneEn[i]) GpioOut[8*i +: 8] <= laneData[8*i +: 8];
      end
   end
`else
   logic unusedGpio;
   assign isGpio     = 1'b0;
   assign memWord    = readWord;
   assign GpioOut    = '0;
   assign unusedGpio = ^{GpioIn, GPIO_ADDR};
`endif

   assign ramWe = (MemWriteM && !sizeMisalign && !isGpio && !RST) ? laneEn : 4'b0000;

   // Write-first read: lanes being written this edge return the new bytes
   always_comb begin
      readWord = ram[wordIdx];
      for (int i = 0; i < 4; i++)
         if (ramWe[i]) readWord[8*i +: 8] = laneData[8*i +: 8];
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < 4; i++)
         if (ramWe[i]) ram[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         RegWriteW  <= 1'b0;
         RdW        <= '0;
         MisalignW  <= 1'b0;
         resultSrcW <= '0;
         strobeW    <= '0;
         addrLoW    <= '0;
         aluW       <= '0;
         extImmW    <= '0;
         pcTargetW  <= '0;
         pcPlus4W   <= '0;
         loadWordW  <= '0;
      end else begin
         RegWriteW  <= RegWriteM & ~misalignedLoad;
         RdW        <= RdM;
         MisalignW  <= sizeMisalign & (isLoad | MemWriteM);
         resultSrcW <= ResultSrcM;
         strobeW    <= StrobeM;
         addrLoW    <= ALUResultM[1:0];
         aluW       <= ALUResultM;
         extImmW    <= ExtImmM;
         pcTargetW  <= PcTargetM;
         pcPlus4W   <= PCPlus4M;
         loadWordW  <= memWord;
      end
   end

   assign byteWord = loadWordW >> {addrLoW, 3'b000};
   assign halfSel  = addrLoW[1] ? loadWordW[31:16] : loadWordW[15:0];

   // Misaligned loads still extract from the aligned lane so the result stays deterministic
   always_comb begin
      case (strobeW)
         3'b000:  loadValue = {{24{byteWord[7]}}, byteWord[7:0]};
         3'b100:  loadValue = {24'b0, byteWord[7:0]};
         3'b001:  loadValue = {{16{halfSel[15]}}, halfSel};
         3'b101:  loadValue = {16'b0, halfSel};
         3'b010:  loadValue = loadWordW;
         default: loadValue = '0;
      endcase
   end

   always_comb begin
      case (resultSrcW)
         3'b000:  ResultW = aluW;
         3'b001:  ResultW = loadValue;
         3'b010:  ResultW = pcPlus4W;
         3'b011:  ResultW = extImmW;
         3'b100:  ResultW = pcTargetW;
         default: ResultW = '0;
      endcase
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: byte-addressed behavioural model compared every cycle, plus literal checks.
module tb_mem_wb_stage;

   localparam int DEPTH_BYTES = 1024 * 4;
   localparam logic [31:0] GPIO = 32'h8000_0000;

   logic        CLK, RST;
   logic        RegWriteM, MemWriteM;
   logic [2:0]  ResultSrcM, StrobeM;
   logic [31:0] ALUResultM, WriteDataM, ExtImmM, PcTargetM, PCPlus4M, GpioIn;
   logic [4:0]  RdM;
   logic        RegWriteW, MisalignW;
   logic [4:0]  RdW;
   logic [31:0] ResultW, GpioOut;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  modelMem [int];
   logic [31:0] modelGpio   = '0;
   logic        expRegWrite = 1'b0;
   logic [4:0]  expRd       = '0;
   logic        expMisalign = 1'b0;
   logic [31:0] expResult   = '0;
   logic        expKnown    = 1'b1;

   mem_wb_stage dut (
      .CLK(CLK), .RST(RST),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
      .StrobeM(StrobeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .RdM(RdM), .ExtImmM(ExtImmM), .PcTargetM(PcTargetM), .PCPlus4M(PCPlus4M),
      .GpioIn(GpioIn), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
      .MisalignW(MisalignW), .GpioOut(GpioOut)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one instruction on the falling edge so it is stable at the next rising edge
   task automatic applyStimulus(input logic rw, input logic [2:0] src, input logic mw,
                                input logic [2:0] strobe, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd);
      @(negedge CLK);
      RegWriteM  = rw;
      ResultSrcM = src;
      MemWriteM  = mw;
      StrobeM    = strobe;
      ALUResultM = addr;
      WriteDataM = wdata;
      RdM        = rd;
   endtask

   task automatic settle();
      @(posedge CLK);
      #1;
   endtask

   // Model: memory as individual bytes, accesses as runs of consecutive bytes
   initial begin
      forever begin
         @(posedge CLK or posedge RST);
         if (RST) begin
            expRegWrite = 1'b0;
            expRd       = '0;
            expMisalign = 1'b0;
            expResult   = '0;
            expKnown    = 1'b1;
            modelGpio   = '0;
         end else begin
            automatic int          size = 0;
            automatic int          base;
            automatic logic        load = (ResultSrcM == 3'd1);
            automatic logic        mis, gpioHit;
            automatic logic [31:0] value = '0;
            automatic logic        known = 1'b1;
            if (StrobeM == 3'd0 || StrobeM == 3'd4) size = 1;
            else if (StrobeM == 3'd1 || StrobeM == 3'd5) size = 2;
            else if (StrobeM == 3'd2) size = 4;
            mis  = (size > 1) && ((ALUResultM % size) != 0) && (load || MemWriteM);
            base = int'(ALUResultM % DEPTH_BYTES);
`ifdef MMIO_GPIO_EN
            gpioHit = (ALUResultM == GPIO);
`else
            gpioHit = 1'b0;
`endif
            if (load && size > 0) begin
               for (int k = 0; k < size; k++) begin
                  automatic logic [7:0] b = '0;
                  if (gpioHit) b = GpioIn[8*k +: 8];
                  else if (modelMem.exists((base + k) % DEPTH_BYTES)) b = modelMem[(base + k) % DEPTH_BYTES];
                  else known = 1'b0;
                  value[8*k +: 8] = b;
               end
               if (StrobeM[2] == 1'b0 && size == 1) value = {{24{value[7]}}, value[7:0]};
               if (StrobeM[2] == 1'b0 && size == 2) value = {{16{value[15]}}, value[15:0]};
            end
            if (load && (mis || size == 0)) known = (size == 0);
            if (MemWriteM && !mis && size > 0) begin
               for (int k = 0; k < size; k++) begin
                  if (gpioHit) modelGpio[8*k +: 8] = WriteDataM[8*k +: 8];
                  else modelMem[(base + k) % DEPTH_BYTES] = WriteDataM[8*k +: 8];
               end
            end
            case (ResultSrcM)
               3'd0:    expResult = ALUResultM;
               3'd1:    expResult = value;
               3'd2:    expResult = PCPlus4M;
               3'd3:    expResult = ExtImmM;
               3'd4:    expResult = PcTargetM;
               default: expResult = '0;
            endcase
            expKnown    = load ? known : 1'b1;
            expRegWrite = RegWriteM && !(mis && load);
            expRd       = RdM;
            expMisalign = mis;
         end
      end
   end

   initial begin
      wait (RST === 1'b1);
      forever begin
         @(negedge CLK);
         checkOutput("cyc_regwrite", {31'b0, RegWriteW}, {31'b0, expRegWrite});
         checkOutput("cyc_rd", {27'b0, RdW}, {27'b0, expRd});
         checkOutput("cyc_misalign", {31'b0, MisalignW}, {31'b0, expMisalign});
         checkOutput("cyc_gpioout", GpioOut, modelGpio);
         if (expKnown) checkOutput("cyc_result", ResultW, expResult);
      end
   end

   initial begin
      RST = 1'b0;
      {RegWriteM, MemWriteM, ResultSrcM, StrobeM, RdM} = '0;
      {ALUResultM, WriteDataM, ExtImmM, PcTargetM, PCPlus4M, GpioIn} = '0;
      #1 RST = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         RegWriteM  = 1'($urandom);
         MemWriteM  = 1'($urandom);
         ResultSrcM = 3'($urandom);
         StrobeM    = 3'($urandom);
         RdM        = 5'($urandom);
         ALUResultM = $urandom;
         WriteDataM = $urandom;
         ExtImmM    = $urandom;
         PcTargetM  = $urandom;
         PCPlus4M   = $urandom;
         GpioIn     = $urandom;
      end
      #1;
      checkOutput("rst_regwrite", {31'b0, RegWriteW}, 32'd0);
      checkOutput("rst_rd", {27'b0, RdW}, 32'd0);
      checkOutput("rst_result", ResultW, 32'd0);
      checkOutput("rst_misalign", {31'b0, MisalignW}, 32'd0);
      checkOutput("rst_gpioout", GpioOut, 32'd0);
      applyStimulus(0, 3'd0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
      RST = 1'b0;

      // Store word, then byte/half loads reading it back
      applyStimulus(0, 3'd0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
      settle(); checkOutput("sw_alu", ResultW, 32'h10);
      applyStimulus(1, 3'd1, 0, 3'b000, 32'h13, 32'h0, 5'd5);
      settle(); checkOutput("lb_sext", ResultW, 32'hFFFFFFDE);
      checkOutput("lb_rd", {27'b0, RdW}, 32'd5);
      applyStimulus(1, 3'd1, 0, 3'b100, 32'h13, 32'h0, 5'd6);
      settle(); checkOutput("lbu_zext", ResultW, 32'h000000DE);
      applyStimulus(1, 3'd1, 0, 3'b101, 32'h10, 32'h0, 5'd7);
      settle(); checkOutput("lhu_zext", ResultW, 32'h0000BEEF);
      applyStimulus(0, 3'd0, 1, 3'b000, 32'h11, 32'h1234565A, 5'd0);
      settle();
      applyStimulus(1, 3'd1, 0, 3'b010, 32'h10, 32'h0, 5'd8);
      settle(); checkOutput("sb_merge", ResultW, 32'hDEAD5AEF);

      // Misaligned store leaves RAM intact; misaligned load suppresses the write-back
      applyStimulus(0, 3'd0, 1, 3'b010, 32'h20, 32'h11223344, 5'd0);
      settle();
      applyStimulus(0, 3'd0, 1, 3'b001, 32'h21, 32'h0000FFFF, 5'd0);
      settle(); checkOutput("sh_mis_flag", {31'b0, MisalignW}, 32'd1);
      applyStimulus(1, 3'd1, 0, 3'b010, 32'h20, 32'h0, 5'd9);
      settle(); checkOutput("sh_mis_ram", ResultW, 32'h11223344);
      checkOutput("mis_pulse_end", {31'b0, MisalignW}, 32'd0);
      applyStimulus(1, 3'd1, 0, 3'b010, 32'h22, 32'h0, 5'd10);
      settle(); checkOutput("lw_mis_regw", {31'b0, RegWriteW}, 32'd0);
      checkOutput("lw_mis_flag", {31'b0, MisalignW}, 32'd1);

      // Back-to-back result sources
      applyStimulus(1, 3'd2, 0, 3'b010, 32'h0, 32'h0, 5'd1);
      PCPlus4M = 32'h104;
      settle(); checkOutput("pc4", ResultW, 32'h104);
      checkOutput("pc4_rd", {27'b0, RdW}, 32'd1);
      applyStimulus(1, 3'd3, 0, 3'b010, 32'h0, 32'h0, 5'd2);
      ExtImmM = 32'h12345000;
      settle(); checkOutput("lui", ResultW, 32'h12345000);
      checkOutput("lui_rd", {27'b0, RdW}, 32'd2);
      applyStimulus(1, 3'd4, 0, 3'b010, 32'h0, 32'h0, 5'd3);
      PcTargetM = 32'h2000;
      settle(); checkOutput("auipc", ResultW, 32'h2000);
      applyStimulus(1, 3'd5, 0, 3'b010, 32'h55, 32'h0, 5'd4);
      settle(); checkOutput("src_other", ResultW, 32'h0);

      // Address wrap and upper-half store
      applyStimulus(0, 3'd0, 1, 3'b010, 32'h2004, 32'hCAFEF00D, 5'd0);
      settle();
      applyStimulus(1, 3'd1, 0, 3'b010, 32'h4, 32'h0, 5'd11);
      settle(); checkOutput("wrap", ResultW, 32'hCAFEF00D);
      applyStimulus(0, 3'd0, 1, 3'b010, 32'h30, 32'h0, 5'd0);
      settle();
      applyStimulus(0, 3'd0, 1, 3'b001, 32'h32, 32'h1234BEEF, 5'd0);
      settle();
      applyStimulus(1, 3'd1, 0, 3'b001, 32'h32, 32'h0, 5'd12);
      settle(); checkOutput("lh_sext", ResultW, 32'hFFFFBEEF);
      applyStimulus(1, 3'd1, 0, 3'b010, 32'h30, 32'h0, 5'd13);
      settle(); checkOutput("sh_upper", ResultW, 32'hBEEF0000);

      // GPIO address: register when mapped, plain wrapped RAM otherwise
      applyStimulus(0, 3'd0, 1, 3'b010, GPIO, 32'h0000A5A5, 5'd0);
      settle();
`ifdef MMIO_GPIO_EN
      checkOutput("gpio_out", GpioOut, 32'h0000A5A5);
`else
      checkOutput("gpio_out", GpioOut, 32'h0);
`endif
      applyStimulus(1, 3'd1, 0, 3'b010, GPIO, 32'h0, 5'd14);
      GpioIn = 32'h77;
      settle();
`ifdef MMIO_GPIO_EN
      checkOutput("gpio_in", ResultW, 32'h77);
`else
      checkOutput("gpio_in", ResultW, 32'h0000A5A5);
`endif

      // Reset mid-cycle drops the pending store and clears W outputs at once
      applyStimulus(0, 3'd0, 1, 3'b010, 32'h40, 32'h11, 5'd0);
      settle();
      applyStimulus(1, 3'd0, 1, 3'b010, 32'h40, 32'h99, 5'd15);
      #2 RST = 1'b1;
      #1 checkOutput("midrst_result", ResultW, 32'h0);
      checkOutput("midrst_regwrite", {31'b0, RegWriteW}, 32'd0);
      applyStimulus(0, 3'd0, 0, 3'b010, 32'h0, 32'h0, 5'd0);
      RST = 1'b0;
      applyStimulus(1, 3'd1, 0, 3'b010, 32'h40, 32'h0, 5'd16);
      settle(); checkOutput("midrst_lost", ResultW, 32'h11);

      applyStimulus(0, 3'd0, 0, 3'b010, 32'h0, 32'h0, 5'd0);
      repeat (2) settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
